vga_timing_ctrl: RTL and testbench

Parametrised VGA raster timing generator with a CPU-visible register window. It is the successor to the fixed 640x480 timing inside gpu. It derives a pixel-clock enable from CLK100MHz and produces hcount/vcount, sync and visible strobes for the pixel pipeline. It also provides vblank and scanline-compare interrupts, which the CPU reads and acknowledges over the 8-bit bus (addr/rw/chip select).

---
 rtl/vga_timing_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_vga_timing_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator with an 8-bit CPU register window and vblank/scanline interrupts.
// Optional feature macro: SCANLINE_IRQ_EN enables LINE_LO/LINE_HI, LINE_PEND and LINE_EN.
module vga_timing_ctrl #(
   parameter int unsigned CLK_DIV   = 4,
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33,
   parameter bit          HS_POL    = 1'b0,
   parameter bit          VS_POL    = 1'b0
) (
   input  logic        CLK100MHz,
   input  logic        rst,
   input  logic [7:0]  data_in,
   output logic [7:0]  data_out,
   input  logic [3:0]  addr,
   input  logic        rw,
   input  logic        cs_n,
   output logic        pix_en,
   output logic [10:0] hcount,
   output logic [10:0] vcount,
   output logic        visible,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        frame_start,
   output logic        irq
);

   localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned CW       = 11;
   localparam int unsigned DW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
   localparam int unsigned HS_END   = HS_START + H_SYNC;
   localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
   localparam int unsigned VS_END   = VS_START + V_SYNC;

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] DIV_PRE  = DW'(CLK_DIV - 2);

   localparam logic [3:0] A_LINE_LO = 4'd0;
   localparam logic [3:0] A_LINE_HI = 4'd1;
   localparam logic [3:0] A_CTRL    = 4'd2;
   localparam logic [3:0] A_STATUS  = 4'd3;
   localparam logic [3:0] A_VCNT_LO = 4'd4;
   localparam logic [3:0] A_VCNT_HI = 4'd5;

   if (CLK_DIV < 2 || H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_param_check
      $error("vga_timing_ctrl: CLK_DIV must be >= 2 and H/V totals must be <= 2048");
   end

   logic [DW-1:0] div_q;
   logic [CW-1:0] h_nxt;
   logic [CW-1:0] v_nxt;
   logic          h_wrap;
   logic          v_wrap;
   logic          line_start;
   logic          frame_wrap;
   logic          vis_nxt;
   logic          hs_act;
   logic          vs_act;
   logic          fs_pend_q;

   logic          cs_q;
   logic          access;
   logic          wr_en;
   logic          rd_pend_q;
   logic [3:0]    rd_addr_q;
   logic [1:0]    ctrl_q;
   logic [1:0]    status_q;
   logic [1:0]    status_set;
   logic [1:0]    status_clr;
   logic [7:0]    line_lo_q;
   logic [2:0]    line_hi_q;
   logic [7:0]    rd_data;

`ifdef SCANLINE_IRQ_EN
   localparam logic [1:0] FLAG_MASK = 2'b11;

   // Scanline compare value, written over the bus
   always_ff @(posedge CLK100MHz or negedge rst) begin
      if (!rst) begin
         line_lo_q <= '0;
         line_hi_q <= '0;
      end else if (wr_en) begin
         if (addr == A_LINE_LO) line_lo_q <= data_in;
         if (addr == A_LINE_HI) line_hi_q <= data_in[2:0];
      end
   end
`else
   localparam logic [1:0] FLAG_MASK = 2'b01;
   logic unused_data;

   assign line_lo_q   = '0;
   assign line_hi_q   = '0;
   assign unused_data = ^data_in[7:2];
`endif

   // Next raster position and its decode; everything is registered from this
   always_comb begin
      h_wrap     = (hcount == CW'(H_TOTAL - 1));
      v_wrap     = (vcount == CW'(V_TOTAL - 1));
      line_start = pix_en & h_wrap;
      frame_wrap = line_start & v_wrap;
      h_nxt      = hcount;
      v_nxt      = vcount;
      if (pix_en)     h_nxt = h_wrap ? '0 : hcount + CW'(1);
      if (line_start) v_nxt = v_wrap ? '0 : vcount + CW'(1);
      vis_nxt = (32'(h_nxt) < H_VISIBLE) && (32'(v_nxt) < V_VISIBLE);
      hs_act  = (32'(h_nxt) >= HS_START) && (32'(h_nxt) < HS_END);
      vs_act  = (32'(v_nxt) >= VS_START) && (32'(v_nxt) < VS_END);
   end

   always_ff @(posedge CLK100MHz or negedge rst) begin
      if (!rst) begin
         div_q       <= '0;
         pix_en      <= 1'b0;
         hcount      <= '0;
         vcount      <= '0;
         visible     <= 1'b1;
         vga_hs      <= ~HS_POL;
         vga_vs      <= ~VS_POL;
         fs_pend_q   <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         div_q       <= (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
         pix_en      <= (div_q == DIV_PRE);
         hcount      <= h_nxt;
         vcount      <= v_nxt;
         visible     <= vis_nxt;
         vga_hs      <= hs_act ? HS_POL : ~HS_POL;
         vga_vs      <= vs_act ? VS_POL : ~VS_POL;
         fs_pend_q   <= frame_wrap;
         frame_start <= fs_pend_q;
      end
   end

   // Bus decode: one access per falling edge of the sampled chip select
   always_comb begin
      access        = cs_q & ~cs_n;
      wr_en         = access & ~rw;
      status_clr    = (wr_en && addr == A_STATUS) ? data_in[1:0] : 2'b00;
      status_set    = 2'b00;
      status_set[0] = line_start && (32'(v_nxt) == V_VISIBLE);
      status_set[1] = line_start && (v_nxt == {line_hi_q, line_lo_q});
      status_set    = status_set & FLAG_MASK;
      case (rd_addr_q)
         A_LINE_LO: rd_data = line_lo_q;
         A_LINE_HI: rd_data = {5'b0, line_hi_q};
         A_CTRL:    rd_data = {6'b0, ctrl_q};
         A_STATUS:  rd_data = {6'b0, status_q};
         A_VCNT_LO: rd_data = vcount[7:0];
         A_VCNT_HI: rd_data = {5'b0, vcount[10:8]};
         default:   rd_data = 8'h00;
      endcase
   end

   // Register file, W1C status (set beats clear) and interrupt
   always_ff @(posedge CLK100MHz or negedge rst) begin
      if (!rst) begin
         cs_q      <= 1'b1;
         rd_pend_q <= 1'b0;
         rd_addr_q <= '0;
         ctrl_q    <= '0;
         status_q  <= '0;
         irq       <= 1'b0;
         data_out  <= '0;
      end else begin
         cs_q      <= cs_n;
         rd_pend_q <= access & rw;
         if (access) rd_addr_q <= addr;
         if (wr_en && addr == A_CTRL) ctrl_q <= data_in[1:0] & FLAG_MASK;
         status_q  <= (status_q & ~status_clr) | status_set;
         irq       <= |(status_q & ctrl_q);
         if (cs_n)           data_out <= 8'h00;
         else if (rd_pend_q) data_out <= rd_data;
      end
   end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Self-checking bench for vga_timing_ctrl on a reduced raster (14x310, divide-by-3).
module tb_vga_timing_ctrl;

   localparam int unsigned DIV = 3;
   localparam int unsigned HV = 8, HF = 2, HSW = 2, HB = 2;
   localparam int unsigned VV = 290, VF = 4, VSW = 2, VB = 14;
   localparam int unsigned HT = HV + HF + HSW + HB;
   localparam int unsigned VT = VV + VF + VSW + VB;
   localparam bit HS_P = 1'b0;
   localparam bit VS_P = 1'b1;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  data_in;
   logic [7:0]  data_out;
   logic [3:0]  addr;
   logic        rw;
   logic        cs_n;
   logic        pix_en;
   logic [10:0] hcount;
   logic [10:0] vcount;
   logic        visible;
   logic        vga_hs;
   logic        vga_vs;
   logic        frame_start;
   logic        irq;

   int unsigned tests = 0;
   int unsigned fails = 0;
   logic [7:0]  exp_q[$];
   string       name_q[$];

   int unsigned m_div, m_h, m_v;
   bit          m_fs_pend, m_fs;

   vga_timing_ctrl #(
      .CLK_DIV(DIV), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
      .HS_POL(HS_P), .VS_POL(VS_P)
   ) dut (
      .CLK100MHz(clk), .rst(rst), .data_in(data_in), .data_out(data_out),
      .addr(addr), .rw(rw), .cs_n(cs_n), .pix_en(pix_en), .hcount(hcount),
      .vcount(vcount), .visible(visible), .vga_hs(vga_hs), .vga_vs(vga_vs),
      .frame_start(frame_start), .irq(irq)
   );

   always #5 clk = ~clk;

   // Reference raster model
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_div <= 0; m_h <= 0; m_v <= 0; m_fs_pend <= 1'b0; m_fs <= 1'b0;
      end else begin
         m_fs      <= m_fs_pend;
         m_fs_pend <= 1'b0;
         if (m_div == DIV - 1) begin
            m_div <= 0;
            if (m_h == HT - 1) begin
               m_h <= 0;
               if (m_v == VT - 1) begin
                  m_v <= 0;
                  m_fs_pend <= 1'b1;
               end else begin
                  m_v <= m_v + 1;
               end
            end else begin
               m_h <= m_h + 1;
            end
         end else begin
            m_div <= m_div + 1;
         end
      end
   end

   function automatic logic [26:0] dut_vec();
      return {pix_en, hcount, vcount, visible, vga_hs, vga_vs, frame_start};
   endfunction

   function automatic logic [26:0] model_vec();
      logic hs_e, vs_e, vis_e;
      hs_e  = (m_h >= HV + HF && m_h < HV + HF + HSW) ? HS_P : ~HS_P;
      vs_e  = (m_v >= VV + VF && m_v < VV + VF + VSW) ? VS_P : ~VS_P;
      vis_e = (m_h < HV) && (m_v < VV);
      return {m_div == DIV - 1, 11'(m_h), 11'(m_v), vis_e, hs_e, vs_e, m_fs};
   endfunction

   function automatic logic [26:0] reset_vec();
      return {1'b0, 11'd0, 11'd0, 1'b1, ~HS_P, ~VS_P, 1'b0};
   endfunction

   task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
      cs_n = 1'b0; rw = 1'b0; addr = a; data_in = d;
      @(negedge clk);
      cs_n = 1'b1; rw = 1'b1;
      @(negedge clk);
   endtask

   task automatic read_check(input logic [3:0] a, input logic [7:0] e, input string nm);
      logic [7:0] want;
      string      wn;
      exp_q.push_back(e);
      name_q.push_back(nm);
      cs_n = 1'b0; rw = 1'b1; addr = a;
      @(negedge clk);
      @(negedge clk);
      want = exp_q.pop_front();
      wn   = name_q.pop_front();
      tests++;
      if (data_out !== want) begin
         fails++;
         $display("FAIL %s: data_out=0x%02h expected 0x%02h", wn, data_out, want);
      end
      @(negedge clk);
      tests++;
      if (data_out !== want) begin
         fails++;
         $display("FAIL %s_hold: data_out=0x%02h expected 0x%02h", wn, data_out, want);
      end
      cs_n = 1'b1;
      @(negedge clk);
      tests++;
      if (data_out !== 8'h00) begin
         fails++;
         $display("FAIL %s_release: data_out=0x%02h expected 0x00", wn, data_out);
      end
   endtask

   task automatic wait_for(input int unsigned h, input int unsigned v, input int unsigned budget,
                           input string nm, output bit ok);
      int unsigned n = 0;
      ok = 1'b0;
      while (n < budget && !ok) begin
         @(negedge clk);
         n++;
         ok = (hcount == 11'(h)) && (vcount == 11'(v));
      end
      if (!ok) begin
         tests++;
         fails++;
         $display("FAIL %s: timeout at h=%0d v=%0d waiting for h=%0d v=%0d", nm, hcount, vcount, h, v);
      end
   endtask

   // Called right after rst is released on a falling edge; release cycle counts as cycle 1
   task automatic check_first_pix(input string nm);
      int unsigned k = 0;
      bit seen = 1'b0;
      while (k < 8 && !seen) begin
         @(posedge clk);
         #1;
         k++;
         seen = pix_en;
      end
      tests++;
      if (!seen || k + 1 != DIV) begin
         fails++;
         $display("FAIL %s: first pix_en in cycle %0d (seen=%0d) expected cycle %0d", nm, k + 1, seen, DIV);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0; cs_n = 1'b1; rw = 1'b1; addr = 4'd0; data_in = 8'h00;
      repeat (3) @(negedge clk);
      tests++;
      if (dut_vec() !== reset_vec()) begin
         fails++;
         $display("FAIL reset_outputs: got 0x%07h expected 0x%07h", dut_vec(), reset_vec());
      end
      tests++;
      if ({data_out, irq} !== 9'h000) begin
         fails++;
         $display("FAIL reset_bus: data_out=0x%02h irq=%0b expected 0x00/0", data_out, irq);
      end
      rst = 1'b1;
      check_first_pix("reset_first_pix");
   endtask

   task automatic test_timing();
      int unsigned n_cyc = DIV * HT * VT + 3 * DIV * HT;
      int unsigned fs_cnt = 0, max_h = 0, max_v = 0;
      for (int unsigned i = 0; i < n_cyc; i++) begin
         @(negedge clk);
         tests++;
         if (dut_vec() !== model_vec()) begin
            fails++;
            $display("FAIL raster cycle %0d: got 0x%07h expected 0x%07h", i, dut_vec(), model_vec());
         end
         if (frame_start === 1'b1) fs_cnt++;
         if (32'(hcount) > max_h) max_h = 32'(hcount);
         if (32'(vcount) > max_v) max_v = 32'(vcount);
      end
      tests++;
      if (fs_cnt != 1) begin
         fails++;
         $display("FAIL frame_start_count: got %0d expected 1", fs_cnt);
      end
      tests++;
      if (max_h != HT - 1 || max_v != VT - 1) begin
         fails++;
         $display("FAIL counter_max: got h=%0d v=%0d expected h=%0d v=%0d", max_h, max_v, HT - 1, VT - 1);
      end
   endtask

   task automatic test_reset_midline();
      bit ok;
      int unsigned tv;
      bus_write(4'd2, 8'h01);
      bus_write(4'd1, 8'h05);
      tv = (32'(vcount) + 1) % VT;
      wait_for(5, tv, 200, "midline_wait", ok);
      #2 rst = 1'b0;
      #1;
      tests++;
      if (dut_vec() !== reset_vec()) begin
         fails++;
         $display("FAIL midline_async_reset: got 0x%07h expected 0x%07h", dut_vec(), reset_vec());
      end
      tests++;
      if ({data_out, irq} !== 9'h000) begin
         fails++;
         $display("FAIL midline_reset_bus: data_out=0x%02h irq=%0b expected 0x00/0", data_out, irq);
      end
      @(negedge clk);
      rst = 1'b1;
      check_first_pix("midline_first_pix");
      read_check(4'd2, 8'h00, "ctrl_after_reset");
      read_check(4'd1, 8'h00, "line_hi_after_reset");
      read_check(4'd3, 8'h00, "status_after_reset");
   endtask

   task automatic test_vblank_irq();
      bit ok;
      bus_write(4'd2, 8'h01);
      wait_for(0, VV, 20000, "vbl_wait", ok);
      tests++;
      if (irq !== 1'b0) begin
         fails++;
         $display("FAIL vbl_irq_latency: irq=%0b expected 0", irq);
      end
      @(negedge clk);
      tests++;
      if (irq !== 1'b1) begin
         fails++;
         $display("FAIL vbl_irq_set: irq=%0b expected 1", irq);
      end
      read_check(4'd3, 8'h01, "status_vbl");
      cs_n = 1'b0; rw = 1'b0; addr = 4'd3; data_in = 8'h01;
      @(negedge clk);
      tests++;
      if (irq !== 1'b1) begin
         fails++;
         $display("FAIL irq_on_clear_edge: irq=%0b expected 1", irq);
      end
      cs_n = 1'b1; rw = 1'b1;
      @(negedge clk);
      tests++;
      if (irq !== 1'b0) begin
         fails++;
         $display("FAIL irq_clear: irq=%0b expected 0", irq);
      end
      read_check(4'd3, 8'h00, "status_cleared");
   endtask

   task automatic test_vcount_read();
      bit ok;
      wait_for(0, 300, 2000, "line300_wait", ok);
      read_check(4'd4, 8'h2C, "vcount_lo");
      read_check(4'd5, 8'h01, "vcount_hi");
   endtask

   task automatic test_unused_addr();
      read_check(4'd7, 8'h00, "unused_7");
      bus_write(4'd9, 8'hFF);
      read_check(4'd2, 8'h01, "ctrl_after_unused_write");
      read_check(4'd15, 8'h00, "unused_15");
   endtask

`ifdef SCANLINE_IRQ_EN
   task automatic test_scanline();
      int unsigned n = 0;
      bit found = 1'b0, early = 1'b0, hit = 1'b0;
      bus_write(4'd3, 8'h03);
      bus_write(4'd1, 8'h01);
      bus_write(4'd0, 8'h00);
      bus_write(4'd2, 8'h02);
      read_check(4'd1, 8'h01, "line_hi_rb");
      read_check(4'd0, 8'h00, "line_lo_rb");
      read_check(4'd2, 8'h02, "ctrl_line_rb");
      while (n < 20000 && !found) begin
         @(negedge clk);
         n++;
         found = (hcount == 11'd0) && (vcount == 11'd256);
         if (!found && irq === 1'b1) early = 1'b1;
      end
      tests++;
      if (!found || early || irq !== 1'b0) begin
         fails++;
         $display("FAIL line_irq_wait: found=%0b early=%0b irq=%0b expected 1/0/0", found, early, irq);
      end
      @(negedge clk);
      tests++;
      if (irq !== 1'b1) begin
         fails++;
         $display("FAIL line_irq_set: irq=%0b expected 1", irq);
      end
      read_check(4'd3, 8'h02, "status_line");
      bus_write(4'd3, 8'h03);
      bus_write(4'd1, 8'h03);
      read_check(4'd1, 8'h03, "line_hi_768_rb");
      for (int unsigned i = 0; i < DIV * HT * VT; i++) begin
         @(negedge clk);
         if (irq === 1'b1) hit = 1'b1;
      end
      tests++;
      if (hit) begin
         fails++;
         $display("FAIL line_768_never: irq seen=%0b expected 0", hit);
      end
      read_check(4'd3, 8'h01, "status_after_768");
   endtask
`else
   task automatic test_scanline();
      bus_write(4'd0, 8'h55);
      bus_write(4'd1, 8'h07);
      read_check(4'd0, 8'h00, "line_lo_absent");
      read_check(4'd1, 8'h00, "line_hi_absent");
      bus_write(4'd2, 8'h03);
      read_check(4'd2, 8'h01, "ctrl_bit1_absent");
   endtask
`endif

   task automatic test_long_select();
      logic [7:0] want;
`ifdef SCANLINE_IRQ_EN
      want = 8'h03;
`else
      want = 8'h01;
`endif
      bus_write(4'd2, 8'h00);
      cs_n = 1'b0; rw = 1'b0; addr = 4'd2; data_in = 8'h03;
      @(negedge clk);
      data_in = 8'h00;
      repeat (19) @(negedge clk);
      cs_n = 1'b1; rw = 1'b1;
      @(negedge clk);
      read_check(4'd2, want, "long_select_ctrl");
   endtask

   initial begin
      test_reset();
      test_timing();
      test_reset_midline();
      test_vblank_irq();
      test_vcount_read();
      test_unused_addr();
      test_scanline();
      test_long_select();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
